// File: rtl/pkt_output_ctrl.sv
// Receive-side packet output controller.
// Checks head/body/tail framing of words arriving from the user module, copies good words
// into the downstream data FIFO and writes one status flag per packet into the valid FIFO.
// Truncated or malformed packets are closed with a forced tail and a 0 status flag.
module pkt_output_ctrl #(
    parameter int unsigned MAX_PKT_WORDS    = 95,
    parameter int unsigned DATA_HIGH_WATER  = 160,
    parameter int unsigned VALID_HIGH_WATER = 60
) (
    input  logic         clk,
    input  logic         reset,
    output logic         um2cdp_tx_enable,
    input  logic         um2cdp_data_valid,
    input  logic [138:0] um2cdp_data,
    output logic         pkt_output_ctrl_wrreq,
    output logic [138:0] pkt_output_ctrl_data,
    input  logic [7:0]   pkt_output_ctrl_usedw,
    output logic         pkt_output_ctrl_valid_wrreq,
    output logic         pkt_output_ctrl_valid,
    input  logic [5:0]   pkt_output_ctrl_valid_usedw,
    output logic [31:0]  pkt_good_cnt,
    output logic [31:0]  pkt_err_cnt
);

    localparam logic [2:0]  HdrHead = 3'b101;
    localparam logic [2:0]  HdrBody = 3'b100;
    localparam logic [2:0]  HdrTail = 3'b110;
    localparam int unsigned CntW    = $clog2(MAX_PKT_WORDS + 1);

    typedef enum logic [1:0] {StIdle, StRecv, StDrop} state_e;

    state_e          r_state;
    logic [CntW-1:0] r_cnt;
    logic            r_tx_en;
    logic            r_wrreq;
    logic [138:0]    r_data;
    logic            r_valid_wrreq;
    logic            r_valid;
    logic [31:0]     r_good_cnt;
    logic [31:0]     r_err_cnt;

    logic [2:0]      w_hdr;
    logic            w_fifo_room;
    logic            w_next_idle;

    assign w_hdr       = um2cdp_data[138:136];
    assign w_fifo_room = (pkt_output_ctrl_usedw < 8'(DATA_HIGH_WATER)) &&
                         (pkt_output_ctrl_valid_usedw < 6'(VALID_HIGH_WATER));

    // Predict whether the FSM will sit in IDLE after this edge; tx_enable follows it.
    always_comb begin
        w_next_idle = 1'b0;
        unique case (r_state)
            StIdle:  w_next_idle = !(um2cdp_data_valid && (w_hdr == HdrHead));
            StRecv:  w_next_idle = um2cdp_data_valid && (w_hdr == HdrTail);
            StDrop:  w_next_idle = um2cdp_data_valid && (w_hdr == HdrTail);
            default: w_next_idle = 1'b1;
        endcase
    end

    // Framing FSM with registered FIFO writes, status flags and counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= StIdle;
            r_cnt         <= '0;
            r_tx_en       <= 1'b0;
            r_wrreq       <= 1'b0;
            r_data        <= '0;
            r_valid_wrreq <= 1'b0;
            r_valid       <= 1'b0;
            r_good_cnt    <= '0;
            r_err_cnt     <= '0;
        end else begin
            r_wrreq       <= 1'b0;
            r_valid_wrreq <= 1'b0;
            r_valid       <= 1'b0;
            r_tx_en       <= w_next_idle && w_fifo_room;
            case (r_state)
                StIdle: begin
                    if (um2cdp_data_valid) begin
                        if (w_hdr == HdrHead) begin
                            r_wrreq <= 1'b1;
                            r_data  <= um2cdp_data;
                            r_cnt   <= CntW'(1);
                            r_state <= StRecv;
                        end else begin
                            r_err_cnt <= r_err_cnt + 32'd1;
                        end
                    end
                end
                StRecv: begin
                    if (um2cdp_data_valid) begin
                        r_wrreq <= 1'b1;
                        r_data  <= um2cdp_data;
                        if (w_hdr == HdrTail) begin
                            r_valid_wrreq <= 1'b1;
                            r_valid       <= 1'b1;
                            r_good_cnt    <= r_good_cnt + 32'd1;
                            r_cnt         <= '0;
                            r_state       <= StIdle;
                        end else if ((w_hdr == HdrBody) &&
                                     (r_cnt < CntW'(MAX_PKT_WORDS - 1))) begin
                            r_cnt <= r_cnt + CntW'(1);
                        end else begin
                            // Close the packet in the FIFO so downstream always sees a tail.
                            r_data        <= {HdrTail, um2cdp_data[135:0]};
                            r_valid_wrreq <= 1'b1;
                            r_valid       <= 1'b0;
                            r_err_cnt     <= r_err_cnt + 32'd1;
                            r_cnt         <= '0;
                            r_state       <= StDrop;
                        end
                    end
                end
                StDrop: begin
                    if (um2cdp_data_valid && (w_hdr == HdrTail)) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign um2cdp_tx_enable            = r_tx_en;
    assign pkt_output_ctrl_wrreq       = r_wrreq;
    assign pkt_output_ctrl_data        = r_data;
    assign pkt_output_ctrl_valid_wrreq = r_valid_wrreq;
    assign pkt_output_ctrl_valid       = r_valid;
    assign pkt_good_cnt                = r_good_cnt;
    assign pkt_err_cnt                 = r_err_cnt;

endmodule

// File: doc/pkt_output_ctrl.md
Name: pkt_output_ctrl

Overview:
- Receive-side counterpart of the packet transmit controller.
- Accepts 139-bit packet words from the user module on the um2cdp interface and checks their framing.
- Writes the words into a downstream 256x139 data FIFO, plus one flag per packet into a 64x1 valid FIFO: 1 = good packet, 0 = truncated/errored.
- Drives um2cdp_tx_enable so the user module only starts a packet when both FIFOs have room for a maximum-length packet.

Parameters:
- MAX_PKT_WORDS, 95: maximum words per packet, head and tail included.
- DATA_HIGH_WATER, 160: tx_enable is withheld when data_usedw >= this value. Must be <= 256 - MAX_PKT_WORDS - 1.
- VALID_HIGH_WATER, 60: tx_enable is withheld when valid_usedw >= this value.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- um2cdp_tx_enable  out  1  permission for the user module to start a new packet
- um2cdp_data_valid  in  1  um2cdp_data carries a word this cycle
- um2cdp_data  in  139  packet word; [138:136] 101 = head, 100 = body, 110 = tail
- pkt_output_ctrl_wrreq  out  1  data FIFO write strobe
- pkt_output_ctrl_data  out  139  data FIFO write word
- pkt_output_ctrl_usedw  in  8  data FIFO fill level
- pkt_output_ctrl_valid_wrreq  out  1  valid FIFO write strobe
- pkt_output_ctrl_valid  out  1  packet-status flag (1 good, 0 error)
- pkt_output_ctrl_valid_usedw  in  6  valid FIFO fill level
- pkt_good_cnt  out  32  count of good packets; wraps
- pkt_err_cnt  out  32  count of framing errors and truncations; wraps

Behaviour:
- Reset, sampled on the clk edge while reset == 0:
  - state = IDLE, word counter = 0.
  - All outputs = 0, including both counters.
  - A partial packet in flight is abandoned. The FIFOs are cleared by the same reset.
- Outputs are registered. A word sampled at edge N appears on pkt_output_ctrl_wrreq/data after edge N, i.e. 1-cycle latency.
- valid_wrreq/valid fire in the same cycle as the tail word's wrreq.
- hdr denotes um2cdp_data[138:136]; every "write" below is registered per this latency rule.
- um2cdp_tx_enable (registered):
  - = 1 only when state == IDLE and data_usedw < DATA_HIGH_WATER and valid_usedw < VALID_HIGH_WATER.
  - Drops to 0 the cycle after a head is accepted. Stays 0 through RECV/DROP.
  - Earliest re-assertion is the cycle after the tail is processed.
- Input words are never back-pressured. The watermark margin guarantees no FIFO overflow. The block does not check for full.
- State IDLE:
  - valid && hdr==101: write word, counter = 1, go to RECV. The head is accepted even if tx_enable = 0.
  - valid && hdr!=101: discard, pkt_err_cnt += 1, stay in IDLE.
- State RECV:
  - valid && hdr==100 && counter < MAX_PKT_WORDS-1: write word, counter += 1.
  - valid && hdr==110: write word, valid_wrreq = 1, valid = 1, pkt_good_cnt += 1, go to IDLE.
  - valid && hdr==100 && counter == MAX_PKT_WORDS-1 (overlength): write the word with [138:136] forced to 110, valid_wrreq = 1, valid = 0, pkt_err_cnt += 1, go to DROP.
  - valid && any other hdr (101, or an illegal code): same as the overlength case — forced tail, valid = 0, err += 1, go to DROP.
  - valid = 0: hold; no timeout.
- State DROP:
  - Discard all words without writing.
  - valid && hdr==110: go to IDLE.
  - A head seen in DROP is also discarded; the block stays in DROP until a tail arrives.
- Invariants:
  - Every packet written to the data FIFO ends with exactly one word whose hdr = 110.
  - That word is paired with exactly one valid-FIFO write.
  - No data write ever occurs without a preceding head in the same packet.
- Simultaneous events: a tail and watermark crossing in the same cycle produce the tail write and leave tx_enable = 0. Counters increment at most once per cycle.

Test Plan:
- Good packet: usedw = 0, drive head, 3 body words, tail back-to-back → 5 writes with identical data, 1-cycle latency; valid_wrreq = 1 with valid = 1 alongside the tail; good_cnt = 1; tx_enable 0 from the cycle after the head, back to 1 the cycle after the tail.
- Watermark: data_usedw = 160, valid_usedw = 0, in IDLE → tx_enable = 0. Drop usedw to 159 → tx_enable = 1 one cycle later. Repeat with valid_usedw = 60/59.
- Overlength: head + 100 body words, no tail → exactly 95 writes; the 95th has hdr 110; valid = 0 written; err_cnt = 1; remaining words dropped until tail; next good packet accepted normally.
- Framing: body word in IDLE → no write, err_cnt = 1. Head, body, head mid-packet → third word written with hdr 110, valid = 0, then DROP until tail.
- Gaps: head, valid = 0 for 10 cycles, body, tail → 3 writes, valid = 1, no error.
- Reset mid-packet: assert reset after head + 2 body words → next edge all outputs 0, state IDLE; a following body word is discarded as a framing error.
